// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the register file with scoreboard.
//   state_e   : init FSM encoding (CLEAR, RUN)
//   DEF_XLEN  : default data width
//   DEF_NREGS : default architectural register count
//   ZERO_REG  : index of the hardwired zero register
package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int ZERO_REG  = 0;

endpackage

// File: rtl/regfile_sb_rdport.sv
// regfile_sb_rdport
// One combinational read port: array data, optional same-cycle write
// forwarding, and zero-forcing for x0 and for the clear sequence.
// Ports:
//   run      in  1     high once the clear sequence is done
//   rd_addr  in  AW    read address
//   rf_data  in  XLEN  raw array contents at rd_addr
//   wr_en    in  1     writeback enable
//   wr_addr  in  AW    writeback destination
//   wr_data  in  XLEN  writeback data
//   rd_data  out XLEN  read result
module regfile_sb_rdport
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            run,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] rd_data
);

    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

    always_comb begin
        rd_data = rf_data;
        if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr))
            rd_data = wr_data;
        // Applied last so a forwarded write to x0 can never leak through.
        if (!run || (rd_addr == ZERO_A))
            rd_data = '0;
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
// Parametrised register file with hardwired x0, write-to-read bypass,
// sequential clear after reset and a per-register busy scoreboard.
// Ports:
//   clock       in  1           rising-edge clock
//   reset       in  1           synchronous active-high reset
//   rd_addr     in  NREAD*AW    packed read addresses, port i = [i*AW +: AW]
//   rd_data     out NREAD*XLEN  packed read data
//   rd_busy     out NREAD       busy bit of each read address
//   wr_en       in  1           writeback enable
//   wr_addr     in  AW          writeback destination
//   wr_data     in  XLEN        writeback data
//   issue_en    in  1           mark issue_addr as pending
//   issue_addr  in  AW          destination being issued
//   ready       out 1           high once the clear sequence has finished
//
// Init FSM
//   state | meaning
//   CLEAR | zeroing one entry per cycle, ports ignored, reads forced to 0
//   RUN   | normal read/write/scoreboard operation until reset
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREGS  = DEF_NREGS,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_addr,
    output logic                  ready
);

    localparam logic [0:0]    ST_CLEAR = 1'(CLEAR);
    localparam logic [0:0]    ST_RUN   = 1'(RUN);
    localparam logic [AW-1:0] ZERO_A   = AW'(ZERO_REG);
    localparam logic [AW:0]   CLR_LAST = (AW+1)'(NREGS - 1);

    logic [XLEN-1:0]  rf [NREGS];
    logic [0:0]       state;
    logic [AW:0]      clr_idx;
    logic             ready_q;
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             run;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [XLEN-1:0]  mem_wdata;

    assign run   = (state == ST_RUN);
    assign ready = ready_q;

    // Clear and writeback share the single array write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (!run) begin
            mem_we    = !reset;
            mem_waddr = clr_idx[AW-1:0];
            mem_wdata = '0;
        end else if (!reset && wr_en && (wr_addr != ZERO_A)) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we)
            rf[mem_waddr] <= mem_wdata;
    end

    // Issue is applied after the write clear so a new producer wins a tie.
    always_comb begin
        busy_nxt = busy;
        if (run) begin
            if (wr_en)
                busy_nxt[wr_addr] = 1'b0;
            if (issue_en)
                busy_nxt[issue_addr] = 1'b1;
        end
        busy_nxt[ZERO_A] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            ready_q <= 1'b0;
            busy    <= '0;
        end else begin
            busy <= busy_nxt;
            if (state == ST_CLEAR) begin
                clr_idx <= clr_idx + (AW+1)'(1);
                if (clr_idx == CLR_LAST) begin
                    state   <= ST_RUN;
                    ready_q <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr       = rd_addr[i*AW +: AW];
        assign rd_busy[i] = run & busy[addr];

        regfile_sb_rdport #(
            .XLEN   (XLEN),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_rdport (
            .run     (run),
            .rd_addr (addr),
            .rf_data (rf[addr]),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_data (rd_data[i*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clock;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        ready_a, ready_b;

    logic        reset_c;
    logic [11:0] rd_addr_c;
    logic [95:0] rd_data_c;
    logic [2:0]  rd_busy_c;
    logic        wr_en_c;
    logic [3:0]  wr_addr_c;
    logic [31:0] wr_data_c;
    logic        issue_en_c;
    logic [3:0]  issue_addr_c;
    logic        ready_c;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    regfile_sb dut_a (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .ready(ready_a)
    );

    regfile_sb #(.BYPASS(0)) dut_b (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .ready(ready_b)
    );

    regfile_sb #(.NREGS(16), .NREAD(3)) dut_c (
        .clock(clock), .reset(reset_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
        .rd_busy(rd_busy_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
        .issue_en(issue_en_c), .issue_addr(issue_addr_c), .ready(ready_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] obs[$];
        string       nm[$];
        logic [31:0] e;
        int          cnt;
        reset = 1; wr_en = 0; issue_en = 0; rd_addr = '0;
        wr_addr = '0; wr_data = '0; issue_addr = '0;
        tick(); tick();
        exp_q.push_back(0); obs.push_back({31'b0, ready_a}); nm.push_back("reset_ready");
        exp_q.push_back(0); obs.push_back({30'b0, rd_busy_a}); nm.push_back("reset_busy");
        rd_addr = {5'd2, 5'd1};
        #1;
        exp_q.push_back(0); obs.push_back(rd_data_a[31:0] | rd_data_a[63:32]); nm.push_back("reset_rd_data");
        reset = 0;
        cnt = 0;
        while (cnt < 200) begin
            wr_en = (cnt < 8); wr_addr = 5'd1; wr_data = 32'hFFFF_FFFF;
            issue_en = (cnt < 8); issue_addr = 5'd2;
            if (cnt == 4) begin
                #1;
                exp_q.push_back(0); obs.push_back(rd_data_a[31:0]); nm.push_back("clear_bypass_blocked");
                exp_q.push_back(0); obs.push_back({30'b0, rd_busy_a}); nm.push_back("clear_busy");
            end
            tick();
            cnt++;
            if (ready_a) break;
        end
        wr_en = 0; issue_en = 0;
        exp_q.push_back(32); obs.push_back(cnt); nm.push_back("ready_latency");
        exp_q.push_back(1); obs.push_back({31'b0, ready_b}); nm.push_back("ready_b");
        for (int i = 1; i < 32; i++) begin
            rd_addr = {5'(i), 5'(i)};
            exp_q.push_back(0);
            #1;
            obs.push_back(rd_data_a[31:0] | rd_data_a[63:32] | {30'b0, rd_busy_a});
            nm.push_back($sformatf("cleared_x%0d", i));
        end
        for (int i = 0; i < obs.size(); i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs[i] !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm[i], obs[i], e);
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] obs[$];
        string       nm[$];
        logic [31:0] e;
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        rd_addr = {5'd0, 5'd5};
        tick();
        wr_en = 0;
        #1;
        exp_q.push_back(32'hDEAD_BEEF); obs.push_back(rd_data_a[31:0]); nm.push_back("x5_p0_a");
        exp_q.push_back(0); obs.push_back(rd_data_a[63:32]); nm.push_back("x0_p1_a");
        exp_q.push_back(32'hDEAD_BEEF); obs.push_back(rd_data_b[31:0]); nm.push_back("x5_p0_b");
        wr_en = 1; wr_addr = 5'd0; wr_data = 32'h0000_1234;
        rd_addr = {5'd5, 5'd0};
        #1;
        exp_q.push_back(0); obs.push_back(rd_data_a[31:0]); nm.push_back("x0_no_bypass");
        tick();
        wr_en = 0;
        #1;
        exp_q.push_back(0); obs.push_back(rd_data_a[31:0]); nm.push_back("x0_after_write");
        exp_q.push_back(32'hDEAD_BEEF); obs.push_back(rd_data_a[63:32]); nm.push_back("x5_p1_a");
        for (int i = 0; i < obs.size(); i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs[i] !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm[i], obs[i], e);
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] obs[$];
        string       nm[$];
        logic [31:0] e;
        wr_en = 1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
        rd_addr = {5'd5, 5'd7};
        exp_q.push_back(32'hA5A5_A5A5);
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(0);
        #1;
        obs.push_back(rd_data_a[31:0]);  nm.push_back("bypass_p0_a");
        obs.push_back(rd_data_a[63:32]); nm.push_back("bypass_other_port");
        obs.push_back(rd_data_b[31:0]);  nm.push_back("nobypass_old_b");
        tick();
        wr_en = 0;
        exp_q.push_back(32'hA5A5_A5A5);
        #1;
        obs.push_back(rd_data_b[31:0]); nm.push_back("nobypass_next_b");
        for (int i = 0; i < obs.size(); i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs[i] !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm[i], obs[i], e);
            end
        end
    endtask

    task automatic test_scoreboard();
        logic [31:0] obs[$];
        string       nm[$];
        logic [31:0] e;
        rd_addr = {5'd0, 5'd3};
        issue_en = 1; issue_addr = 5'd3;
        #1;
        exp_q.push_back(0); obs.push_back({31'b0, rd_busy_a[0]}); nm.push_back("x3_busy_before");
        tick();
        issue_en = 0;
        #1;
        exp_q.push_back(1); obs.push_back({31'b0, rd_busy_a[0]}); nm.push_back("x3_busy_set");
        wr_en = 1; wr_addr = 5'd3; wr_data = 32'd9;
        #1;
        exp_q.push_back(1); obs.push_back({31'b0, rd_busy_a[0]}); nm.push_back("x3_busy_not_bypassed");
        exp_q.push_back(9); obs.push_back(rd_data_a[31:0]); nm.push_back("x3_data_bypass");
        tick();
        wr_en = 0;
        #1;
        exp_q.push_back(0); obs.push_back({31'b0, rd_busy_a[0]}); nm.push_back("x3_busy_cleared");
        exp_q.push_back(9); obs.push_back(rd_data_a[31:0]); nm.push_back("x3_data");
        issue_en = 1; issue_addr = 5'd0;
        rd_addr = {5'd3, 5'd0};
        tick();
        issue_en = 0;
        #1;
        exp_q.push_back(0); obs.push_back({30'b0, rd_busy_a}); nm.push_back("x0_never_busy");
        for (int i = 0; i < obs.size(); i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs[i] !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm[i], obs[i], e);
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] obs[$];
        string       nm[$];
        logic [31:0] e;
        rd_addr = {5'd6, 5'd4};
        issue_en = 1; issue_addr = 5'd4;
        tick();
        #1;
        exp_q.push_back(1); obs.push_back({31'b0, rd_busy_a[0]}); nm.push_back("x4_busy_set");
        wr_en = 1; wr_addr = 5'd4; wr_data = 32'd2;
        issue_en = 1; issue_addr = 5'd4;
        tick();
        wr_en = 0; issue_en = 0;
        #1;
        exp_q.push_back(2); obs.push_back(rd_data_a[31:0]); nm.push_back("same_addr_data");
        exp_q.push_back(1); obs.push_back({31'b0, rd_busy_a[0]}); nm.push_back("same_addr_busy");
        wr_en = 1; wr_addr = 5'd4; wr_data = 32'd3;
        issue_en = 1; issue_addr = 5'd6;
        tick();
        wr_en = 0; issue_en = 0;
        #1;
        exp_q.push_back(2'b10); obs.push_back({30'b0, rd_busy_a}); nm.push_back("diff_addr_busy");
        exp_q.push_back(3); obs.push_back(rd_data_a[31:0]); nm.push_back("diff_addr_data");
        for (int i = 0; i < obs.size(); i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs[i] !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm[i], obs[i], e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] obs[$];
        string       nm[$];
        logic [31:0] e;
        int          cnt;
        wr_en = 1; wr_addr = 5'd10; wr_data = 32'd1;
        issue_en = 1; issue_addr = 5'd11;
        rd_addr = {5'd11, 5'd10};
        tick();
        wr_en = 0; issue_en = 0;
        #1;
        exp_q.push_back(1); obs.push_back(rd_data_a[31:0]); nm.push_back("x10_before_reset");
        exp_q.push_back(2'b10); obs.push_back({30'b0, rd_busy_a}); nm.push_back("x11_busy_before_reset");
        reset = 1;
        tick();
        reset = 0;
        #1;
        exp_q.push_back(0); obs.push_back({31'b0, ready_a}); nm.push_back("mid_reset_ready");
        exp_q.push_back(0); obs.push_back({30'b0, rd_busy_a}); nm.push_back("mid_reset_busy");
        cnt = 0;
        while (cnt < 200) begin
            tick();
            cnt++;
            if (ready_a) break;
        end
        exp_q.push_back(32); obs.push_back(cnt); nm.push_back("mid_reset_latency");
        #1;
        exp_q.push_back(0); obs.push_back(rd_data_a[31:0]); nm.push_back("x10_cleared");
        exp_q.push_back(0); obs.push_back({30'b0, rd_busy_a}); nm.push_back("x11_busy_cleared");
        for (int i = 0; i < obs.size(); i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs[i] !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm[i], obs[i], e);
            end
        end
    endtask

    task automatic test_small();
        logic [31:0] obs[$];
        string       nm[$];
        logic [31:0] e;
        int          cnt;
        wr_en_c = 0; issue_en_c = 0; rd_addr_c = '0;
        wr_addr_c = '0; wr_data_c = '0; issue_addr_c = '0;
        reset_c = 1;
        tick();
        reset_c = 0;
        cnt = 0;
        while (cnt < 200) begin
            tick();
            cnt++;
            if (ready_c) break;
        end
        exp_q.push_back(16); obs.push_back(cnt); nm.push_back("c_ready_latency");
        wr_en_c = 1; wr_addr_c = 4'd15; wr_data_c = 32'h1111_0015;
        tick();
        wr_addr_c = 4'd1; wr_data_c = 32'h2222_0001;
        tick();
        wr_en_c = 0;
        issue_en_c = 1; issue_addr_c = 4'd9;
        tick();
        issue_en_c = 0;
        rd_addr_c = {4'd9, 4'd1, 4'd15};
        wr_en_c = 1; wr_addr_c = 4'd9; wr_data_c = 32'h0000_9999;
        #1;
        exp_q.push_back(32'h1111_0015); obs.push_back(rd_data_c[31:0]);  nm.push_back("c_p0_x15");
        exp_q.push_back(32'h2222_0001); obs.push_back(rd_data_c[63:32]); nm.push_back("c_p1_x1");
        exp_q.push_back(32'h0000_9999); obs.push_back(rd_data_c[95:64]); nm.push_back("c_p2_bypass");
        exp_q.push_back(3'b100); obs.push_back({29'b0, rd_busy_c}); nm.push_back("c_busy_x9");
        tick();
        wr_en_c = 0;
        rd_addr_c = {4'd0, 4'd9, 4'd15};
        #1;
        exp_q.push_back(0); obs.push_back(rd_data_c[95:64]); nm.push_back("c_p2_x0");
        exp_q.push_back(32'h0000_9999); obs.push_back(rd_data_c[63:32]); nm.push_back("c_p1_x9");
        exp_q.push_back(0); obs.push_back({29'b0, rd_busy_c}); nm.push_back("c_busy_clear");
        reset_c = 1;
        tick();
        reset_c = 0;
        #1;
        exp_q.push_back(0); obs.push_back({31'b0, ready_c}); nm.push_back("c_mid_reset_ready");
        cnt = 0;
        while (cnt < 200) begin
            tick();
            cnt++;
            if (ready_c) break;
        end
        exp_q.push_back(16); obs.push_back(cnt); nm.push_back("c_mid_reset_latency");
        rd_addr_c = {4'd1, 4'd9, 4'd15};
        #1;
        exp_q.push_back(0); obs.push_back(rd_data_c[31:0] | rd_data_c[63:32] | rd_data_c[95:64]);
        nm.push_back("c_cleared");
        for (int i = 0; i < obs.size(); i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs[i] !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm[i], obs[i], e);
            end
        end
    endtask

    initial begin
        reset_c = 1; wr_en_c = 0; issue_en_c = 0; rd_addr_c = '0;
        wr_addr_c = '0; wr_data_c = '0; issue_addr_c = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_mid_reset();
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
